// File: rtl/fetch_unit.sv
// Thumb instruction fetch unit: reads 32-bit words, serves 16-bit instructions.
// Define FETCH_HALFWORD_BUF_EN to serve the upper halfword from the word buffer.
//
// Parameters:
//   RESET_PC       first fetch address after reset
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   mem_req        instruction memory read request (held until mem_ack)
//   mem_addr       word-aligned read address, 0 when no request
//   mem_ack        single-cycle read completion, mem_rdata valid with it
//   mem_rdata      32-bit read data
//   instr_out      16-bit instruction, 0 while instr_valid=0
//   instr_valid    instr_out holds a valid instruction
//   instr_ready    decoder accepts instr_out
//   branch_taken   redirect fetch to branch_target (bit0 ignored)
//   branch_target  redirect address
//   next_pc        PC value for the register file
//   pc_en          next_pc is to be loaded (transfer or branch)
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [15:0] instr_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] next_pc,
    output logic        pc_en
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
    } state_t;

    localparam logic [31:0] RESET_ADDR = RESET_PC & ~32'd1;

    state_t      state;
    logic [31:0] fetch_addr;
    logic [31:0] buf_word;
    // A branch while a read is outstanding leaves one stale ack in flight.
    logic        kill;

    logic [31:0] tgt;
    logic [31:0] addr_inc;
    logic        xfer;
    logic        take_ack;
    logic        hit;

    assign tgt      = branch_target & ~32'd1;
    assign addr_inc = fetch_addr + 32'd2;
    assign xfer     = !reset && (state == VALID) && instr_ready;
    assign take_ack = (state == REQ) && mem_ack && !kill && !branch_taken;

`ifdef FETCH_HALFWORD_BUF_EN
    logic [29:0] buf_tag;
    logic        buf_valid;

    assign hit = buf_valid && (buf_tag == addr_inc[31:2]);
`else
    assign hit = 1'b0;
`endif

    // Outputs are forced to reset values for the whole reset window,
    // including the first cycle before the registers have been cleared.
    assign mem_req     = !reset && (state == REQ);
    assign mem_addr    = mem_req ? {fetch_addr[31:2], 2'b00} : 32'd0;
    assign instr_valid = !reset && (state == VALID);
    assign instr_out   = !instr_valid  ? 16'h0000 :
                         fetch_addr[1] ? buf_word[31:16] :
                                         buf_word[15:0];
    assign pc_en       = !reset && (branch_taken || xfer);
    assign next_pc     = reset        ? RESET_ADDR :
                         branch_taken ? tgt :
                         xfer         ? addr_inc :
                                        fetch_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fetch_addr <= RESET_ADDR;
            buf_word   <= 32'd0;
            kill       <= 1'b0;
`ifdef FETCH_HALFWORD_BUF_EN
            buf_tag    <= 30'd0;
            buf_valid  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (take_ack) begin
                        buf_word <= mem_rdata;
`ifdef FETCH_HALFWORD_BUF_EN
                        buf_tag   <= fetch_addr[31:2];
                        buf_valid <= 1'b1;
`endif
                        state <= VALID;
                    end
                end
                VALID: begin
                    if (xfer) begin
                        fetch_addr <= addr_inc;
                        state      <= hit ? VALID : REQ;
                    end
                end
                default: state <= IDLE;
            endcase

            if (branch_taken && (state == REQ) && !mem_ack)
                kill <= 1'b1;
            else if (mem_ack)
                kill <= 1'b0;

            // Redirect overrides every update above.
            if (branch_taken) begin
                fetch_addr <= tgt;
                state      <= REQ;
`ifdef FETCH_HALFWORD_BUF_EN
                buf_valid  <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for the reset/first fetch,
// hand sequences for stall, branch, branch+transfer, wrap and mid-request reset.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'd0) return 32'h2222_1111;
        return {4'hB, a[11:0], 4'hA, a[11:0]};
    endfunction

    // Instance A: RESET_PC = 0
    logic        reset_a = 1'b1;
    logic        ready_a = 1'b0;
    logic        br_a    = 1'b0;
    logic [31:0] tgt_a   = 32'd0;
    logic        req_a;
    logic [31:0] addr_a;
    logic        ack_a   = 1'b0;
    logic [31:0] rdata_a = 32'd0;
    logic [15:0] ins_a;
    logic        vld_a;
    logic [31:0] npc_a;
    logic        pce_a;
    int          acc0_a  = 0;
    int          tot_a   = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) u_a (
        .clk(clk), .reset(reset_a),
        .mem_req(req_a), .mem_addr(addr_a),
        .mem_ack(ack_a), .mem_rdata(rdata_a),
        .instr_out(ins_a), .instr_valid(vld_a),
        .instr_ready(ready_a),
        .branch_taken(br_a), .branch_target(tgt_a),
        .next_pc(npc_a), .pc_en(pce_a)
    );

    // Memory model: latches a request, acks it one cycle later.
    always @(posedge clk) begin
        if (ack_a) begin
            ack_a <= 1'b0;
        end else if (req_a) begin
            ack_a   <= 1'b1;
            rdata_a <= word(addr_a);
            tot_a   <= tot_a + 1;
            if (addr_a == 32'd0) acc0_a <= acc0_a + 1;
        end
    end

    // Instance B: RESET_PC = FFFF_FFFC for the wrap case
    logic        reset_b = 1'b1;
    logic        ready_b = 1'b0;
    logic        req_b;
    logic [31:0] addr_b;
    logic        ack_b   = 1'b0;
    logic [31:0] rdata_b = 32'd0;
    logic [15:0] ins_b;
    logic        vld_b;
    logic [31:0] npc_b;
    logic        pce_b;
    logic [31:0] reqq_b[$];

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_b (
        .clk(clk), .reset(reset_b),
        .mem_req(req_b), .mem_addr(addr_b),
        .mem_ack(ack_b), .mem_rdata(rdata_b),
        .instr_out(ins_b), .instr_valid(vld_b),
        .instr_ready(ready_b),
        .branch_taken(1'b0), .branch_target(32'd0),
        .next_pc(npc_b), .pc_en(pce_b)
    );

    always @(posedge clk) begin
        if (ack_b) begin
            ack_b <= 1'b0;
        end else if (req_b) begin
            ack_b   <= 1'b1;
            rdata_b <= word(addr_b);
            reqq_b.push_back(addr_b);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        ntests++;
        nfail++;
        $display("FAIL %s: timeout waiting for DUT", nm);
    endtask

    task automatic wait_valid_a(input string nm);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            if (vld_a) return;
        end
        timeout(nm);
    endtask

    // Stops in the first cycle of a request (memory not yet acking).
    task automatic wait_req_a(input string nm);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (req_a && !ack_a) return;
        end
        timeout(nm);
    endtask

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [15:0] ins;
        logic        pce;
        logic [31:0] npc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic rdy, input logic req,
                       input logic [31:0] addr, input logic vld,
                       input logic [15:0] ins, input logic pce,
                       input logic [31:0] npc);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.req = req; v.addr = addr;
        v.vld = vld; v.ins = ins; v.pce = pce; v.npc = npc;
        tbl.push_back(v);
    endtask

    logic [31:0] exp_npc[4] = '{32'hFFFF_FFFE, 32'h0, 32'h2, 32'h4};
    logic [15:0] exp_ins[4] = '{16'hAFFC, 16'hBFFC, 16'h1111, 16'h2222};

    initial begin
        int snap;
        int n;
        int exp_acc;

        // Reset, first fetch of word 0, two halfwords.
        add(1, 1, 0, 32'h0, 0, 16'h0,    0, 32'h0);
        add(1, 1, 0, 32'h0, 0, 16'h0,    0, 32'h0);
        add(0, 1, 0, 32'h0, 0, 16'h0,    0, 32'h0);
        add(0, 1, 1, 32'h0, 0, 16'h0,    0, 32'h0);
        add(0, 1, 1, 32'h0, 0, 16'h0,    0, 32'h0);
        add(0, 1, 0, 32'h0, 1, 16'h1111, 1, 32'h2);
`ifdef FETCH_HALFWORD_BUF_EN
        add(0, 1, 0, 32'h0, 1, 16'h2222, 1, 32'h4);
        exp_acc = 1;
`else
        add(0, 1, 1, 32'h0, 0, 16'h0,    0, 32'h2);
        add(0, 1, 1, 32'h0, 0, 16'h0,    0, 32'h2);
        add(0, 1, 0, 32'h0, 1, 16'h2222, 1, 32'h4);
        exp_acc = 2;
`endif
        add(0, 0, 1, 32'h4, 0, 16'h0,    0, 32'h4);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset_a = tbl[i].rst;
            ready_a = tbl[i].rdy;
            #1;
            chk($sformatf("vec%0d.mem_req", i), 32'(req_a), 32'(tbl[i].req));
            chk($sformatf("vec%0d.mem_addr", i), addr_a, tbl[i].addr);
            chk($sformatf("vec%0d.valid", i), 32'(vld_a), 32'(tbl[i].vld));
            chk($sformatf("vec%0d.instr", i), 32'(ins_a), 32'(tbl[i].ins));
            chk($sformatf("vec%0d.pc_en", i), 32'(pce_a), 32'(tbl[i].pce));
            chk($sformatf("vec%0d.next_pc", i), npc_a, tbl[i].npc);
        end
        @(negedge clk);
        chk("first.reads_of_word0", 32'(acc0_a), 32'(exp_acc));

        // Stall with instr_ready low for 5 cycles.
        if (!vld_a) wait_valid_a("stall.wait");
        snap = tot_a;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("stall%0d.instr", i), 32'(ins_a), 32'h0000_A004);
            chk($sformatf("stall%0d.valid", i), 32'(vld_a), 32'h1);
            chk($sformatf("stall%0d.pc_en", i), 32'(pce_a), 32'h0);
        end
        chk("stall.no_new_req", 32'(tot_a), 32'(snap));
        @(negedge clk);
        ready_a = 1'b1;
        #1;
        chk("stall.release.pc_en", 32'(pce_a), 32'h1);
        chk("stall.release.next_pc", npc_a, 32'h6);

        // Branch during REQ, stale ack must be dropped.
        wait_req_a("branch.wait_req");
        br_a  = 1'b1;
        tgt_a = 32'h0000_0103;
        #1;
        chk("branch.pc_en", 32'(pce_a), 32'h1);
        chk("branch.next_pc", npc_a, 32'h102);
        @(negedge clk);
        br_a    = 1'b0;
        ready_a = 1'b0;
        #1;
        chk("branch.valid_drop", 32'(vld_a), 32'h0);
        chk("branch.mem_addr", addr_a, 32'h100);
        chk("branch.pc_en_off", 32'(pce_a), 32'h0);
        wait_valid_a("branch.wait_valid");
        chk("branch.first_instr", 32'(ins_a), 32'h0000_B100);

        // Transfer and branch in the same cycle.
        ready_a = 1'b1;
        br_a    = 1'b1;
        tgt_a   = 32'h0000_0040;
        #1;
        chk("xbr.pc_en", 32'(pce_a), 32'h1);
        chk("xbr.next_pc", npc_a, 32'h40);
        @(negedge clk);
        br_a    = 1'b0;
        ready_a = 1'b0;
        #1;
        chk("xbr.mem_req", 32'(req_a), 32'h1);
        chk("xbr.mem_addr", addr_a, 32'h40);
        chk("xbr.valid", 32'(vld_a), 32'h0);
        chk("xbr.pc_en_off", 32'(pce_a), 32'h0);
        wait_valid_a("xbr.wait_valid");
        chk("xbr.instr", 32'(ins_a), 32'h0000_A040);
        ready_a = 1'b1;
        #1;
        chk("xbr.next_after", npc_a, 32'h42);

        // Reset asserted while a request is outstanding.
        wait_req_a("rst.wait_req");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            reset_a = 1'b1;
            ready_a = 1'b1;
            #1;
            chk($sformatf("rst%0d.mem_req", i), 32'(req_a), 32'h0);
            chk($sformatf("rst%0d.mem_addr", i), addr_a, 32'h0);
            chk($sformatf("rst%0d.valid", i), 32'(vld_a), 32'h0);
            chk($sformatf("rst%0d.instr", i), 32'(ins_a), 32'h0);
            chk($sformatf("rst%0d.pc_en", i), 32'(pce_a), 32'h0);
            chk($sformatf("rst%0d.next_pc", i), npc_a, 32'h0);
        end
        @(negedge clk);
        reset_a = 1'b0;
        ready_a = 1'b0;
        #1;
        chk("rst.idle.mem_req", 32'(req_a), 32'h0);
        chk("rst.idle.valid", 32'(vld_a), 32'h0);
        @(negedge clk);
        #1;
        chk("rst.restart.mem_req", 32'(req_a), 32'h1);
        chk("rst.restart.mem_addr", addr_a, 32'h0);
        wait_valid_a("rst.wait_valid");
        chk("rst.restart.instr", 32'(ins_a), 32'h0000_1111);

        // Address wrap on instance B.
        @(negedge clk);
        @(negedge clk);
        reset_b = 1'b0;
        ready_b = 1'b1;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            #1;
            if (pce_b) begin
                chk($sformatf("wrap%0d.next_pc", n), npc_b, exp_npc[n]);
                chk($sformatf("wrap%0d.instr", n), 32'(ins_b), 32'(exp_ins[n]));
                n++;
            end
        end
        if (n < 4) timeout("wrap.transfers");
        ready_b = 1'b0;
        if (reqq_b.size() == 0) begin
            timeout("wrap.reqs");
        end else begin
            chk("wrap.first_addr", reqq_b[0], 32'hFFFF_FFFC);
            n = 0;
            while (n < reqq_b.size() && reqq_b[n] == 32'hFFFF_FFFC) n++;
            if (n < reqq_b.size())
                chk("wrap.second_addr", reqq_b[n], 32'h0);
            else
                timeout("wrap.second_addr");
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got %0d failures before stop",
                 nfail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 The block SHALL have port mem_req, output, 1 bit: instruction memory read request.
REQ-005 The block SHALL have port mem_addr, output, 32 bits: word-aligned read address.
REQ-006 The block SHALL have port mem_ack, input, 1 bit: single-cycle read completion.
REQ-007 The block SHALL have port mem_rdata, input, 32 bits: read data, valid only while mem_ack=1.
REQ-008 The block SHALL have port instr_out, output, 16 bits: Thumb instruction to the decoder.
REQ-009 The block SHALL have port instr_valid, output, 1 bit: instr_out holds a valid instruction.
REQ-010 The block SHALL have port instr_ready, input, 1 bit: the decoder accepts instr_out.
REQ-011 The block SHALL have port branch_taken, input, 1 bit: redirect fetch.
REQ-012 The block SHALL have port branch_target, input, 32 bits: redirect address.
REQ-013 The block SHALL have port next_pc, output, 32 bits: PC value for the register file.
REQ-014 The block SHALL have port pc_en, output, 1 bit: next_pc is to be loaded.

Function
REQ-015 The block SHALL keep an internal 32-bit fetch_addr with bit0 always 0; branch_target[0] is ignored.
REQ-016 The block SHALL implement the FSM states IDLE, REQ and VALID.
- IDLE: entered from reset, left unconditionally to REQ after one cycle.
- REQ: mem_req=1; transition to VALID on mem_ack.
- VALID: instr_valid=1.
REQ-017 In REQ, mem_addr SHALL equal {fetch_addr[31:2],2'b00} and SHALL stay stable until mem_ack.
REQ-018 On mem_ack, mem_rdata SHALL be captured into a 32-bit word buffer tagged with fetch_addr[31:2]; instr_valid rises the following cycle.
REQ-019 instr_out SHALL be buffer[15:0] when fetch_addr[1]=0 and buffer[31:16] when fetch_addr[1]=1, and SHALL be 16'h0000 when instr_valid=0.
REQ-020 A transfer (instr_valid & instr_ready) SHALL set fetch_addr to fetch_addr+2 (mod 2^32, wrap from 32'hFFFF_FFFE to 0), with next_pc = new fetch_addr and pc_en=1 in the same cycle.
REQ-021 instr_out and instr_valid SHALL stay stable while instr_valid=1 and instr_ready=0.
REQ-022 After a transfer, if the buffer tag matches the new fetch_addr[31:2], the FSM SHALL stay in VALID with no bubble; otherwise it SHALL go to REQ.
REQ-023 branch_taken SHALL have priority over all other events in any state:
- fetch_addr := branch_target with bit0 cleared;
- buffer invalidated, FSM to REQ next cycle;
- next_pc = cleared target and pc_en=1 in that cycle;
- instr_valid=0 from the next cycle.
REQ-024 A mem_ack coincident with branch_taken, or arriving for a request issued before a branch, SHALL be discarded.
REQ-025 A transfer coincident with branch_taken SHALL be consumed without incrementing fetch_addr; the branch update wins.
REQ-026 pc_en SHALL be 0 in every cycle without a transfer or branch.

Reset
REQ-027 While reset=1 the block SHALL hold: FSM=IDLE, fetch_addr=RESET_PC, buffer invalid, mem_req=0, mem_addr=0, instr_valid=0, instr_out=0, pc_en=0, next_pc=RESET_PC.
REQ-028 Reset asserted mid-request SHALL abandon the request, and any mem_ack during reset or in the first IDLE cycle SHALL be ignored.

Configuration
REQ-029 Macro FETCH_HALFWORD_BUF_EN SHALL control buffer reuse.
- Defined: REQ-022 applies; the upper halfword is served from the buffer.
- Undefined: every transfer returns the FSM to REQ, giving one memory read per instruction.

Verification
REQ-030 The bench SHALL cover the following directed scenarios:
- Reset release, RESET_PC=0, mem_ack one cycle after mem_req, instr_ready=1 -> mem_addr=0; instrs 0x1111 then 0x2222 from word 0x2222_1111; next_pc 2 then 4; only one mem_req with _EN defined, two without.
- Stall: instr_ready=0 for 5 cycles -> instr_out held, pc_en=0, no new mem_req.
- branch_taken with target 0x0000_0103 during REQ, then a late mem_ack -> data discarded; next fetch mem_addr=0x100; first instr is the upper halfword; next_pc=0x102.
- Transfer and branch in the same cycle (target 0x40) -> fetch_addr=0x40, not old+2; one pc_en with next_pc=0x40.
- Wrap: RESET_PC=0xFFFF_FFFC, four transfers -> mem_addr 0xFFFF_FFFC then 0x0; next_pc sequence FFFF_FFFE, 0, 2, 4.
- reset asserted while mem_req=1, then mem_ack during reset -> all outputs at reset values; fetch restarts at RESET_PC.
